// File: rtl/sseg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode seven-segment display.
// It drives the digit select, the active-low anodes with a blanking gap at each slot start, and the slot/frame ticks.
module sseg_scan_ctrl #(
  parameter int CLK_DIV      = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] dig_en,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic       slot_tick,
  output logic       frame_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [3:0]       AN_OFF    = 4'b1111;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  if (CLK_DIV < 4) begin : g_div_check
    $error("sseg_scan_ctrl: CLK_DIV must be at least 4");
  end
  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= CLK_DIV) begin : g_blank_check
    $error("sseg_scan_ctrl: BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < CLK_DIV");
  end

  logic             state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       sel_nxt;
  logic [3:0]       an_nxt;
  logic             start;
  logic             wrap;
  logic             slot_nxt;
  logic             frame_nxt;

  // From idle, the first active edge opens slot 0 at cnt=0 instead of advancing.
  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    start     = (state == ST_IDLE);
    wrap      = (state == ST_RUN) && (cnt == CNT_LAST);
    cnt_nxt   = cnt + CNT_W'(1);
    sel_nxt   = sel;
    an_nxt    = AN_OFF;
    slot_nxt  = 1'b0;
    frame_nxt = 1'b0;
    if (start) begin
      cnt_nxt   = '0;
      sel_nxt   = 2'd0;
      slot_nxt  = 1'b1;
      frame_nxt = 1'b1;
    end else if (wrap) begin
      cnt_nxt   = '0;
      sel_nxt   = sel + 2'd1;
      slot_nxt  = 1'b1;
      frame_nxt = (sel == 2'd3);
    end
    // an is computed from the next slot position, so the register and the slot stay aligned.
    if (cnt_nxt >= CNT_BLANK && dig_en[sel_nxt]) begin
      an_nxt = ~(4'b0001 << sel_nxt);
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sel        <= 2'd0;
      an         <= AN_OFF;
      slot_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      state      <= ST_RUN;
      cnt        <= cnt_nxt;
      sel        <= sel_nxt;
      an         <= an_nxt;
      slot_tick  <= slot_nxt;
      frame_tick <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Scoreboard bench for sseg_scan_ctrl with CLK_DIV=8 and BLANK_CYCLES=2.
// The stimulus process queues the output it expects after each edge; the monitor pops and compares those outputs after that edge.
module tb_sseg_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] dig_en;
  logic [1:0] sel;
  logic [3:0] an;
  logic       slot_tick;
  logic       frame_tick;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [1:0] sel;
    logic [3:0] an;
    logic       st;
    logic       ft;
  } exp_t;

  exp_t exp_q[$];

  sseg_scan_ctrl #(.CLK_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .dig_en     (dig_en),
    .sel        (sel),
    .an         (an),
    .slot_tick  (slot_tick),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got sel/an/st/ft=%b required %b at %0t", name, act, req, $time);
    end
  endtask

  // Expected output for cycle c of slot s while running with mask m.
  function automatic exp_t run_exp(input string name, input int s, input int c,
                                   input logic [3:0] m);
    exp_t e;
    e.name = name;
    e.sel  = 2'(s);
    e.an   = 4'b1111;
    if (c >= 2 && m[s]) begin
      case (s)
        0: e.an = 4'b1110;
        1: e.an = 4'b1101;
        2: e.an = 4'b1011;
        default: e.an = 4'b0111;
      endcase
    end
    e.st = (c == 0);
    e.ft = (c == 0) && (s == 0);
    return e;
  endfunction

  function automatic exp_t idle_exp(input string name);
    exp_t e;
    e.name = name;
    e.sel  = 2'd0;
    e.an   = 4'b1111;
    e.st   = 1'b0;
    e.ft   = 1'b0;
    return e;
  endfunction

  task automatic step(input logic r, input logic e, input logic [3:0] m, input exp_t x);
    reset  = r;
    en     = e;
    dig_en = m;
    exp_q.push_back(x);
    @(posedge clk);
    #2;
  endtask

  task automatic run_slot(input string name, input int s, input int c0, input int c1,
                          input logic [3:0] m);
    for (int c = c0; c <= c1; c++) step(1'b0, 1'b1, m, run_exp(name, s, c, m));
  endtask

  // Monitor: outputs are valid every cycle, compared 1 ns after each edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check(x.name, {sel, an, slot_tick, frame_tick}, {x.sel, x.an, x.st, x.ft});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    reset  = 1'b1;
    en     = 1'b1;
    dig_en = 4'b1111;
    @(posedge clk);
    #2;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'b1111, idle_exp("reset_hold"));

    for (int s = 0; s < 4; s++) run_slot("full_mask", s, 0, 7, 4'b1111);
    for (int s = 0; s < 4; s++) run_slot("mask_1010", s, 0, 7, 4'b1010);

    run_slot("pre_drop", 0, 0, 7, 4'b1111);
    run_slot("pre_drop", 1, 0, 7, 4'b1111);
    run_slot("pre_drop", 2, 0, 5, 4'b1111);
    step(1'b0, 1'b0, 4'b1111, idle_exp("en_drop"));
    step(1'b0, 1'b0, 4'b1111, idle_exp("en_low"));

    for (int s = 0; s < 3; s++) run_slot("en_restart", s, 0, 7, 4'b1111);
    run_slot("pre_reset", 3, 0, 6, 4'b1111);
    step(1'b1, 1'b1, 4'b1111, idle_exp("reset_pulse"));

    run_slot("post_reset", 0, 0, 7, 4'b1111);
    run_slot("mask_toggle", 1, 0, 3, 4'b1111);
    run_slot("mask_toggle", 1, 4, 7, 4'b1101);
    run_slot("boundary_kept", 2, 0, 1, 4'b1111);

    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
